lfsr_frame_packer: RTL and testbench
====================================

// Module: lfsr_frame_packer
// PURPOSE
//  Downstream of the LFSR scrambler: buffers scrambled 32-bit words (no backpressure from source)
//  and emits fixed-length frames on a valid/ready stream: header, seed, FRAME_WORDS payload, checksum.
//  Header/seed words carry the polynomial select and seed so the receive side can re-seed its descrambler.
// PARAMETERS
//  FRAME_WORDS  16     payload words per frame (>=1, <=FIFO_DEPTH)
//  FIFO_DEPTH   32     input buffer depth in words, power of 2
//  SYNC_WORD    16'hA5C3  header sync pattern, header bits [31:16]
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  in_data        in   32  scrambled word from scrambler data_out
//  in_valid       in   1   scrambler data_valid_out; word present this cycle
//  hdr_seed       in   32  seed value driven to scrambler
//  hdr_poly       in   3   polynomial select driven to scrambler
//  hdr_capture    in   1   pulse, same cycle as scrambler seed_load; latches hdr_seed/hdr_poly
//  out_data       out  32  frame word
//  out_valid      out  1   out_data valid
//  out_ready      in   1   sink accepts; transfer = out_valid & out_ready
//  out_sof        out  1   qualifies header word
//  out_eof        out  1   qualifies checksum word
//  overflow       out  1   sticky: input word dropped
//  clear_overflow in   1   synchronous clear of overflow
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, out_sof=0, out_eof=0, overflow=0; FIFO empty; frame_seq=0;
//   pending seed=32'h1, pending poly=3'b000 (matches scrambler reset state). Reset mid-frame aborts frame.
//  FIFO: push when in_valid & (!full | pop this cycle); in_valid & full & !pop -> word dropped, overflow<=1.
//   clear_overflow and a same-cycle drop: set wins (overflow stays 1).
//  hdr_capture: pending_seed<=hdr_seed, pending_poly<=hdr_poly. Takes effect for the next frame that
//   leaves IDLE; if capture and IDLE->HDR occur in the same cycle, the new values are used (bypass).
//  FSM: IDLE -> HDR -> SEED -> PAY -> CSUM -> IDLE.
//   IDLE: when fifo_count >= FRAME_WORDS, latch frame_seed/frame_poly, load header into output reg,
//    go HDR. Header = {SYNC_WORD, 5'b0, frame_poly, frame_seq[7:0]}; out_sof=1.
//   HDR: on transfer load frame_seed, go SEED.
//   SEED: on transfer pop FIFO head into output, clear checksum, go PAY.
//   PAY: each transfer XORs the word into checksum; after FRAME_WORDS transfers load checksum,
//    out_eof=1, go CSUM. Payload never underruns (frame starts only with full payload buffered).
//   CSUM: on transfer out_valid<=0, frame_seq<=frame_seq+1 (8-bit wrap 255->0), go IDLE.
//  Checksum = XOR of the FRAME_WORDS payload words as emitted.
//  Handshake: out_valid/out_data/out_sof/out_eof held stable until transfer; out_ready may toggle freely.
//  Latency: header out_valid rises 1 cycle after fifo_count reaches FRAME_WORDS in IDLE.
//  Throughput: out_ready=1 -> FRAME_WORDS+3 consecutive words, then >=1 IDLE cycle (out_valid=0).
//  FIFO keeps filling during frame output; drops only occur on full.
// STRUCTURE
//  Package lfsr_frame_pkg: state enum (IDLE,HDR,SEED,PAY,CSUM), SYNC_WORD default,
//   header field positions (sync [31:16], poly [10:8], seq [7:0]).
//  Sub-module sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH): push/pop, full/empty, count.
//  Top: capture regs, FSM, output register, checksum, frame_seq, overflow.
// TESTING
//  1 Reset, hdr_capture seed=32'hDEADBEEF poly=2, push 16 words 1..16, out_ready=1 -> 19-word frame:
//    32'hA5C30200 (sof), 32'hDEADBEEF, 1..16, checksum 32'h00000010 (eof).
//  2 Same stimulus, out_ready toggled 1/0 each cycle -> identical word sequence, data stable while stalled.
//  3 out_ready=0, push 33 words -> 32 buffered, overflow=1; clear_overflow -> 0; drop+clear same cycle -> 1.
//  4 Send 257 frames -> header seq field 0..255 then 0 on frame 257.
//  5 hdr_capture poly=3 during frame N payload -> frame N header unchanged, frame N+1 header poly=3.
//  6 Assert reset_n low mid-PAY -> all outputs 0 immediately; next frame starts seq=0, seed 32'h1.

Source files
------------

// File: rtl/lfsr_frame_pkg.sv
// lfsr_frame_pkg: shared state encoding, header layout and header builder for the frame packer
package lfsr_frame_pkg;
  typedef enum logic [2:0] {IDLE, HDR, SEED, PAY, CSUM} state_t;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
  localparam int SYNC_LSB = 16;
  localparam int POLY_LSB = 8;
  localparam int SEQ_LSB = 0;
  function automatic logic [31:0] make_header(input logic [15:0] sync, input logic [2:0] poly,
                                              input logic [7:0] seq);
    make_header = (32'(sync) << SYNC_LSB) | (32'(poly) << POLY_LSB) | (32'(seq) << SEQ_LSB);
  endfunction
endpackage

// File: rtl/lfsr_frame_packer_fifo.sv
// sync_fifo: single-clock first-word-fall-through buffer with occupancy count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign rdata = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  // storage array, written at the tail pointer
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/lfsr_frame_packer.sv
// lfsr_frame_packer: buffers scrambled words and emits header/seed/payload/checksum frames
module lfsr_frame_packer
  import lfsr_frame_pkg::*;
#(
  parameter int          FRAME_WORDS = 16,
  parameter int          FIFO_DEPTH  = 32,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic [31:0] hdr_seed,
  input  logic [2:0]  hdr_poly,
  input  logic        hdr_capture,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic        overflow,
  input  logic        clear_overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(FRAME_WORDS + 1);
  state_t state, state_n;
  logic [31:0] pend_seed, frame_seed, csum, head, seed_eff;
  logic [2:0] pend_poly, poly_eff;
  logic [7:0] seq;
  logic [BW-1:0] beat;
  logic [CW-1:0] count;
  logic full, empty, push, pop, xfer, last, start, drop;
  assign xfer = out_valid & out_ready;
  assign last = beat == BW'(FRAME_WORDS - 1);
  assign start = count >= CW'(FRAME_WORDS);
  assign pop = xfer & !empty & (state == SEED | (state == PAY & !last));
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;
  assign seed_eff = hdr_capture ? hdr_seed : pend_seed;
  assign poly_eff = hdr_capture ? hdr_poly : pend_poly;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .wdata(in_data),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );

  // pending seed/poly for the next frame, reset to the scrambler's reset state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_seed <= 32'h1;
      pend_poly <= 3'b000;
    end else if (hdr_capture) begin
      pend_seed <= hdr_seed;
      pend_poly <= hdr_poly;
    end

  // sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;

  // frame state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  // frame sequencing: each stage advances on an accepted word
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? HDR : IDLE;
      HDR:     state_n = xfer ? SEED : HDR;
      SEED:    state_n = xfer ? PAY : SEED;
      PAY:     state_n = xfer & last ? CSUM : PAY;
      CSUM:    state_n = xfer ? IDLE : CSUM;
      default: state_n = IDLE;
    endcase
  end

  // output register, checksum and sequence number; outputs only change on a transfer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_data <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      frame_seed <= '0;
      csum <= '0;
      beat <= '0;
      seq <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          frame_seed <= seed_eff;
          out_data <= make_header(SYNC_WORD, poly_eff, seq);
          out_valid <= 1'b1;
          out_sof <= 1'b1;
        end
        HDR: if (xfer) begin
          out_data <= frame_seed;
          out_sof <= 1'b0;
        end
        SEED: if (xfer) begin
          out_data <= head;
          csum <= '0;
          beat <= '0;
        end
        PAY: if (xfer) begin
          csum <= csum ^ out_data;
          beat <= beat + BW'(1);
          out_data <= last ? csum ^ out_data : head;
          out_eof <= last;
        end
        CSUM: if (xfer) begin
          out_valid <= 1'b0;
          out_eof <= 1'b0;
          seq <= seq + 8'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_lfsr_frame_packer.sv
// tb_lfsr_frame_packer: scoreboard bench with a frame-level reference model
module tb_lfsr_frame_packer;
  localparam int FW = 16;
  logic clk = 0, reset_n = 0;
  logic [31:0] in_data = 0, hdr_seed = 0, out_data;
  logic in_valid = 0, hdr_capture = 0, out_ready = 0, clear_overflow = 0;
  logic [2:0] hdr_poly = 0;
  logic out_valid, out_sof, out_eof, overflow;
  int vectors = 0, miscompares = 0, nxfer = 0, rmode = 0;
  logic [33:0] sb[$];
  logic [31:0] pay[$];
  logic [31:0] m_seed = 32'h1;
  logic [2:0] m_poly = 0;
  logic [7:0] m_seq = 0;

  lfsr_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .hdr_seed(hdr_seed), .hdr_poly(hdr_poly), .hdr_capture(hdr_capture),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .overflow(overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // reference model: a frame is fully determined once its payload words are in
  task automatic model_push(input logic [31:0] w);
    logic [31:0] c;
    pay.push_back(w);
    if (pay.size() == FW) begin
      c = 0;
      sb.push_back({2'b10, 16'hA5C3, 5'b0, m_poly, m_seq});
      sb.push_back({2'b00, m_seed});
      foreach (pay[i]) begin
        sb.push_back({2'b00, pay[i]});
        c = c ^ pay[i];
      end
      sb.push_back({2'b01, c});
      pay.delete();
      m_seq = m_seq + 8'd1;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    pay.delete();
    m_seed = 32'h1;
    m_poly = 0;
    m_seq = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    in_data = w;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    model_push(w);
  endtask

  task automatic capture(input logic [31:0] s, input logic [2:0] p);
    hdr_seed = s;
    hdr_poly = p;
    hdr_capture = 1;
    @(posedge clk);
    #1;
    hdr_capture = 0;
    m_seed = s;
    m_poly = p;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 0);
    chk({tag, "_data"}, 64'(out_data), 0);
    chk({tag, "_sof"}, 64'(out_sof), 0);
    chk({tag, "_eof"}, 64'(out_eof), 0);
    chk({tag, "_ovf"}, 64'(overflow), 0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    idle(2);
    check_zero("reset");
    reset_n = 1;
    idle(1);
  endtask

  task automatic wait_xfer(input int target);
    int i = 0;
    while (nxfer < target && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("xfer_wait", 64'(nxfer >= target), 1);
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 20000) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_left", 64'(sb.size()), 0);
    idle(3);
  endtask

  // sink: ready pattern chosen by the running test
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !out_ready :
                rmode == 2 ? ($urandom_range(7) != 0) : 1'b0;
  end

  // monitor: pops the scoreboard on every transfer, checks stall stability and the idle gap
  logic stalled = 0, gap_due = 0;
  logic [33:0] prev_word = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 0;
      gap_due = 0;
    end else begin
      if (gap_due) chk("idle_gap", 64'(out_valid), 0);
      if (out_valid) begin
        if (stalled) chk("stall_stable", 64'({out_sof, out_eof, out_data}), 64'(prev_word));
        if (out_ready) begin
          nxfer++;
          if (sb.size() == 0) chk("unexpected_word", 64'({out_sof, out_eof, out_data}), 64'hFFFF);
          else chk("word", 64'({out_sof, out_eof, out_data}), 64'(sb.pop_front()));
        end
      end
      gap_due = out_valid & out_ready & out_eof;
      stalled = out_valid & !out_ready;
      prev_word = {out_sof, out_eof, out_data};
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    idle(1);
    do_reset();
    // 1: known frame, sink always ready
    rmode = 0;
    capture(32'hDEADBEEF, 3'd2);
    for (int i = 1; i <= FW; i++) push(32'(i));
    drain();
    // 2: same words, sink toggling
    rmode = 1;
    capture(32'hDEADBEEF, 3'd2);
    for (int i = 1; i <= FW; i++) push(32'(i));
    drain();
    // 3: fill to full with sink stalled, then exercise the sticky drop flag
    rmode = 3;
    idle(2);
    for (int i = 0; i < 32; i++) push($urandom);
    in_data = 32'hBAD0BAD0;
    in_valid = 1;
    idle(1);
    in_valid = 0;
    chk("ovf_set", 64'(overflow), 1);
    clear_overflow = 1;
    idle(1);
    clear_overflow = 0;
    chk("ovf_clear", 64'(overflow), 0);
    in_valid = 1;
    clear_overflow = 1;
    idle(1);
    in_valid = 0;
    clear_overflow = 0;
    chk("ovf_set_wins", 64'(overflow), 1);
    clear_overflow = 1;
    idle(1);
    clear_overflow = 0;
    rmode = 0;
    drain();
    // 4: 257 frames so the sequence field wraps
    do_reset();
    rmode = 2;
    for (int f = 0; f < 257; f++)
      for (int w = 0; w < FW; w++) begin
        idle($urandom_range(0, 2));
        push($urandom);
      end
    drain();
    chk("ovf_none", 64'(overflow), 0);
    // 5: capture during a payload applies only to the next frame
    capture(32'h0BADF00D, 3'd1);
    base = nxfer;
    for (int i = 0; i < FW; i++) push($urandom);
    wait_xfer(base + 3);
    capture($urandom, 3'd3);
    for (int i = 0; i < FW; i++) push($urandom);
    drain();
    // 6: reset mid-payload aborts the frame; next frame restarts from reset values
    rmode = 0;
    capture(32'h12345678, 3'd5);
    base = nxfer;
    for (int i = 0; i < FW; i++) push($urandom);
    wait_xfer(base + 4);
    #2 reset_n = 0;
    #1 check_zero("async_rst");
    model_reset();
    idle(2);
    reset_n = 1;
    idle(1);
    for (int i = 0; i < FW; i++) push($urandom);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
